// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : flag_branch_unit
// Purpose  : Program-counter sequencer. Fetches from start to halt and
//            resolves conditional relative branches against the LT/OV flags.
//            A branch that coincides with a flag write waits one cycle so it
//            sees the updated flags.
// Options  : BRANCH_COUNT_EN - adds a saturating taken-branch counter
//            (br_count output).
// Revision : 1.0 - initial release
// ============================================================================
module flag_branch_unit #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_lt,
  input  logic             br_ov,
  input  logic             br_uncond,
  input  logic [OFF_W-1:0] br_off,
  input  logic             lt_in,
  input  logic             ov_in,
  input  logic             flag_w,
  output logic [PC_W-1:0]  pc,
  output logic             instr_valid,
  output logic             taken,
  output logic             busy,
`ifdef BRANCH_COUNT_EN
  output logic [15:0]      br_count,
`endif
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_INTLK = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_nxt;
  logic              r_busy;
  logic              r_done;
  logic              w_instr_valid;
  logic              w_taken;
  logic              w_any_br;
  logic              w_cond;
  logic [PC_W-1:0]   w_off_ext;

  // Branch decode: any select raises a branch; selected conditions are ORed.
  assign w_any_br  = br_uncond | br_lt | br_ov;
  assign w_cond    = br_uncond | (br_lt & lt_in) | (br_ov & ov_in);
  // Sign-extend the relative offset to the pc width; the add wraps mod 2^PC_W.
  assign w_off_ext = PC_W'($signed(br_off));

  // Next-state, next-pc and the two decoded (unregistered) outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_instr_valid = 1'b0;
    w_taken       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = start_addr;
        end
      end
      S_RUN: begin
        // stall freezes everything, including the branch decision
        if (!stall) begin
          if (halt) begin
            w_instr_valid = 1'b1;
            w_state_nxt   = S_DONE;
          end else if (w_any_br && flag_w) begin
            // flags are in flight: re-evaluate the branch next cycle
            w_state_nxt = S_INTLK;
          end else if (w_cond) begin
            w_instr_valid = 1'b1;
            w_taken       = 1'b1;
            w_pc_nxt      = r_pc + w_off_ext;
            w_state_nxt   = S_FLUSH;
          end else begin
            w_instr_valid = 1'b1;
            w_pc_nxt      = r_pc + PC_W'(1);
          end
        end
      end
      S_INTLK: begin
        if (!stall) begin
          w_state_nxt = S_RUN;
        end
      end
      S_FLUSH: begin
        if (!stall) begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = start_addr;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // reset dominates: no execute or taken indication while it is asserted
    if (reset) begin
      w_instr_valid = 1'b0;
      w_taken       = 1'b0;
    end
  end

  // State, pc and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_INTLK) ||
                 (w_state_nxt == S_FLUSH);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

`ifdef BRANCH_COUNT_EN
  logic [15:0] r_br_count;

  // Saturating count of taken branches, cleared when a new run is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_br_count <= '0;
    end else if (start && ((r_state == S_IDLE) || (r_state == S_DONE))) begin
      r_br_count <= '0;
    end else if (w_taken && (r_br_count != 16'hFFFF)) begin
      r_br_count <= r_br_count + 16'd1;
    end
  end

  assign br_count = r_br_count;
`endif

  assign pc          = r_pc;
  assign busy        = r_busy;
  assign done        = r_done;
  assign instr_valid = w_instr_valid;
  assign taken       = w_taken;

endmodule
`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_flag_branch_unit
// Purpose  : Self-checking bench for flag_branch_unit. Each cycle's inputs
//            and the outputs expected during that cycle are listed as
//            records; expectations are queued when inputs are driven and
//            compared on the following falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flag_branch_unit;

  localparam int PC_W  = 10;
  localparam int OFF_W = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [PC_W-1:0]  start_addr;
  logic             stall;
  logic             halt;
  logic             br_lt;
  logic             br_ov;
  logic             br_uncond;
  logic [OFF_W-1:0] br_off;
  logic             lt_in;
  logic             ov_in;
  logic             flag_w;
  logic [PC_W-1:0]  pc;
  logic             instr_valid;
  logic             taken;
  logic             busy;
  logic             done;
`ifdef BRANCH_COUNT_EN
  logic [15:0]      br_count;
`endif

  flag_branch_unit #(.PC_W(PC_W), .OFF_W(OFF_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_addr  (start_addr),
    .stall       (stall),
    .halt        (halt),
    .br_lt       (br_lt),
    .br_ov       (br_ov),
    .br_uncond   (br_uncond),
    .br_off      (br_off),
    .lt_in       (lt_in),
    .ov_in       (ov_in),
    .flag_w      (flag_w),
    .pc          (pc),
    .instr_valid (instr_valid),
    .taken       (taken),
    .busy        (busy),
`ifdef BRANCH_COUNT_EN
    .br_count    (br_count),
`endif
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic            st;
    logic [PC_W-1:0] sa;
    logic            stl;
    logic            hlt;
    logic            blt;
    logic            bov;
    logic            bun;
    logic [OFF_W-1:0] off;
    logic            lt;
    logic            ov;
    logic            fw;
    logic [PC_W-1:0] epc;
    logic            eiv;
    logic            etk;
    logic            ebusy;
    logic            edone;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic rst, input logic st, input logic [PC_W-1:0] sa,
    input logic stl, input logic hlt, input logic blt, input logic bov,
    input logic bun, input logic [OFF_W-1:0] off,
    input logic lt, input logic ov, input logic fw,
    input logic [PC_W-1:0] epc, input logic eiv, input logic etk,
    input logic ebusy, input logic edone);
    vec_t v;
    v.rst = rst; v.st = st; v.sa = sa; v.stl = stl; v.hlt = hlt;
    v.blt = blt; v.bov = bov; v.bun = bun; v.off = off;
    v.lt = lt; v.ov = ov; v.fw = fw;
    v.epc = epc; v.eiv = eiv; v.etk = etk; v.ebusy = ebusy; v.edone = edone;
    return v;
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue its
  // expected outputs.
  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    reset      = v.rst;
    start      = v.st;
    start_addr = v.sa;
    stall      = v.stl;
    halt       = v.hlt;
    br_lt      = v.blt;
    br_ov      = v.bov;
    br_uncond  = v.bun;
    br_off     = v.off;
    lt_in      = v.lt;
    ov_in      = v.ov;
    flag_w     = v.fw;
    sb.push_back(v);
  endtask

  task automatic chk1(input string name, input logic [PC_W-1:0] act,
                      input logic [PC_W-1:0] exp, input int idx);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Scoreboard: compare the oldest queued expectation on the falling edge.
  int vec_idx = 0;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      chk1("pc",          pc,                         e.epc,                  vec_idx);
      chk1("instr_valid", {{(PC_W-1){1'b0}}, instr_valid}, {{(PC_W-1){1'b0}}, e.eiv},   vec_idx);
      chk1("taken",       {{(PC_W-1){1'b0}}, taken},  {{(PC_W-1){1'b0}}, e.etk},   vec_idx);
      chk1("busy",        {{(PC_W-1){1'b0}}, busy},   {{(PC_W-1){1'b0}}, e.ebusy}, vec_idx);
      chk1("done",        {{(PC_W-1){1'b0}}, done},   {{(PC_W-1){1'b0}}, e.edone}, vec_idx);
      vec_idx++;
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; start_addr = '0; stall = 1'b0; halt = 1'b0;
    br_lt = 1'b0; br_ov = 1'b0; br_uncond = 1'b0; br_off = '0;
    lt_in = 1'b0; ov_in = 1'b0; flag_w = 1'b0;
    @(posedge clk);

    //                rst st sa      stl hlt blt bov bun off    lt ov fw  pc      iv tk by dn
    // reset state, start, sequential fetch, start ignored while busy
    tbl.push_back(mk(1, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 10'h010, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h010, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h011, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h012, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 10'h020, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h013, 1, 0, 1, 0));
    // jump to 0x020, then backward LT branch -16 to 0x010
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 1, 8'h0C, 0, 0, 0, 10'h014, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h020, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 1, 0, 0, 8'hF0, 1, 0, 0, 10'h020, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h010, 0, 0, 1, 0));
    // LT branch with LT clear falls through; OV branch ignores LT
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 1, 0, 0, 8'hF0, 0, 1, 0, 10'h010, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h011, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 1, 0, 8'h20, 1, 0, 0, 10'h012, 1, 0, 1, 0));
    // jump to 0x030, OV branch coinciding with a flag write -> interlock
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 1, 8'h1D, 0, 0, 0, 10'h013, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h030, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 1, 0, 8'h05, 0, 0, 1, 10'h030, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 1, 0, 8'h05, 0, 1, 0, 10'h030, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 1, 0, 8'h05, 0, 1, 0, 10'h030, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h035, 0, 0, 1, 0));
    // halt, restart at 0x3FF, pc wraps to 0x000
    tbl.push_back(mk(0, 0, 10'h000, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h035, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 10'h3FF, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h035, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h3FF, 1, 0, 1, 0));
    // backward branch wraps to 0x3F0, max forward offset wraps to 0x06F
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 1, 8'hF0, 0, 0, 0, 10'h000, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h3F0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 1, 8'h7F, 0, 0, 0, 10'h3F0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h06F, 0, 0, 1, 0));
    // to 0x055, halt beats branch, DONE holds, restart at 0x000
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 1, 8'hE6, 0, 0, 0, 10'h06F, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h055, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 1, 0, 0, 1, 8'h10, 0, 0, 0, 10'h055, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 1, 8'h10, 0, 0, 0, 10'h055, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h055, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h000, 1, 0, 1, 0));
    // offset 0 self-loop
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 10'h001, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h001, 0, 0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
    end

    // Hand sequence: FLUSH stretched by a 3-cycle stall, stall in RUN and INTLK
    step(mk(0, 0, 10'h000, 0, 0, 0, 0, 1, 8'h04, 0, 0, 0, 10'h001, 1, 1, 1, 0));
    for (int k = 0; k < 3; k++) begin
      step(mk(0, 0, 10'h000, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h005, 0, 0, 1, 0));
    end
    step(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h005, 0, 0, 1, 0));
    step(mk(0, 0, 10'h000, 1, 1, 0, 0, 1, 8'h10, 0, 0, 0, 10'h005, 0, 0, 1, 0));
    step(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h005, 1, 0, 1, 0));
    step(mk(0, 0, 10'h000, 0, 0, 1, 0, 0, 8'h02, 0, 0, 1, 10'h006, 0, 0, 1, 0));
    step(mk(0, 0, 10'h000, 1, 0, 1, 0, 0, 8'h02, 1, 0, 0, 10'h006, 0, 0, 1, 0));
    step(mk(0, 0, 10'h000, 0, 0, 1, 0, 0, 8'h02, 1, 0, 0, 10'h006, 0, 0, 1, 0));
    step(mk(0, 0, 10'h000, 0, 0, 1, 0, 0, 8'h02, 1, 0, 0, 10'h006, 1, 1, 1, 0));
    // reset during FLUSH, then during a RUN cycle with a branch pending
    step(mk(1, 0, 10'h000, 0, 0, 0, 0, 1, 8'h10, 0, 0, 0, 10'h008, 0, 0, 1, 0));
    step(mk(0, 1, 10'h100, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h000, 0, 0, 0, 0));
    step(mk(1, 0, 10'h000, 0, 0, 0, 0, 1, 8'h10, 0, 0, 0, 10'h100, 0, 0, 1, 0));
    step(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h000, 0, 0, 0, 0));

`ifdef BRANCH_COUNT_EN
    // three taken branches counted from a fresh start, cleared by reset
    step(mk(0, 1, 10'h100, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h000, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      step(mk(0, 0, 10'h000, 0, 0, 0, 0, 1, 8'h01, 0, 0, 0, 10'h100 + 10'(k), 1, 1, 1, 0));
      step(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h101 + 10'(k), 0, 0, 1, 0));
    end
    drain();
    checks++;
    if (br_count !== 16'd3) begin
      errors++;
      $display("FAIL br_count_after_3: got %0d expected 3", br_count);
    end
    step(mk(1, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h103, 0, 0, 1, 0));
    step(mk(0, 0, 10'h000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h000, 0, 0, 0, 0));
    drain();
    checks++;
    if (br_count !== 16'd0) begin
      errors++;
      $display("FAIL br_count_after_reset: got %0d expected 0", br_count);
    end
`endif

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
